// File: rtl/ram_arbiter.sv
// Shares the program/data RAM between the stack processor and a loader port.
// The processor is frozen via cpu_haltN while the loader owns the RAM.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CPU_MIN  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_readWriteN,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_haltN,
  input  logic              ld_req,
  input  logic              ld_readWriteN,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              ram_readWriteN,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_CPU, ST_HALT, ST_LOAD, ST_RESTORE} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cpu_window;
  logic             ld_accept_c;

  assign ld_accept_c = (state == ST_LOAD) && ld_gnt && ld_req;
  assign cpu_data_in = ram_data_in;
  assign ld_rdata    = ram_data_in;

  // Ownership FSM; cpu_window starts saturated so the first grant is not delayed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CPU;
      cpu_haltN  <= 1'b1;
      ld_gnt     <= 1'b0;
      ld_rvalid  <= 1'b0;
      hold_cnt   <= '0;
      cpu_window <= CNT_W'(CPU_MIN);
    end else begin
      ld_rvalid <= ld_accept_c && ld_readWriteN;
      case (state)
        ST_CPU: begin
          if (ld_req && (cpu_window >= CNT_W'(CPU_MIN))) begin
            state     <= ST_HALT;
            cpu_haltN <= 1'b0;
          end else if (cpu_window < CNT_W'(CPU_MIN)) begin
            cpu_window <= cpu_window + CNT_W'(1);
          end
        end
        ST_HALT: begin
          state    <= ST_LOAD;
          ld_gnt   <= 1'b1;
          hold_cnt <= '0;
        end
        ST_LOAD: begin
          if (!ld_req) begin
            state  <= ST_RESTORE;
            ld_gnt <= 1'b0;
          end else if (ld_gnt) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            if (hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
              state  <= ST_RESTORE;
              ld_gnt <= 1'b0;
            end
          end
        end
        ST_RESTORE: begin
          state      <= ST_CPU;
          cpu_haltN  <= 1'b1;
          cpu_window <= '0;
        end
        default: state <= ST_CPU;
      endcase
    end
  end

  // While frozen, the processor address is re-read so its pending data is ready on resume
  always_comb begin
    ram_readWriteN = cpu_readWriteN;
    ram_address    = cpu_address;
    ram_data_out   = cpu_data_out;
    case (state)
      ST_HALT, ST_RESTORE: ram_readWriteN = 1'b1;
      ST_LOAD: begin
        if (ld_gnt) begin
          ram_readWriteN = ld_readWriteN | ~ld_req;
          ram_address    = ld_address;
          ram_data_out   = ld_wdata;
        end else begin
          ram_readWriteN = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_readWriteN = 1'b1;
  logic [7:0] cpu_address = 8'h00;
  logic [7:0] cpu_data_out = 8'h00;
  logic [7:0] cpu_data_in;
  logic       cpu_haltN;
  logic       ld_req = 1'b0;
  logic       ld_readWriteN = 1'b1;
  logic [7:0] ld_address = 8'h00;
  logic [7:0] ld_wdata = 8'h00;
  logic       ld_gnt;
  logic [7:0] ld_rdata;
  logic       ld_rvalid;
  logic       ram_readWriteN;
  logic [7:0] ram_address;
  logic [7:0] ram_data_out;
  logic [7:0] ram_data_in;

  int n_vec = 0;
  int n_bad = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .HOLD_MAX(4), .CPU_MIN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_readWriteN(cpu_readWriteN), .cpu_address(cpu_address),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .cpu_haltN(cpu_haltN),
    .ld_req(ld_req), .ld_readWriteN(ld_readWriteN), .ld_address(ld_address),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .ram_readWriteN(ram_readWriteN), .ram_address(ram_address),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!ram_readWriteN) mem[ram_address] <= ram_data_out;
    ram_data_in <= mem[ram_address];
  end

  typedef struct {
    logic       ld_req, ld_rw;
    logic [7:0] ld_addr, ld_wd;
    logic       cpu_rw;
    logic [7:0] cpu_addr, cpu_wd;
    logic       e_haltN, e_gnt, e_rv, e_rw;
    logic [7:0] e_addr, e_wd;
    logic       chk_d;
    logic [7:0] e_d;
  } vec_t;

  function automatic vec_t mk(logic lr, logic lrw, logic [7:0] la, logic [7:0] lw,
                              logic crw, logic [7:0] ca, logic [7:0] cw,
                              logic eh, logic eg, logic ev, logic erw,
                              logic [7:0] ea, logic [7:0] ew, logic cd, logic [7:0] ed);
    vec_t v;
    v.ld_req = lr; v.ld_rw = lrw; v.ld_addr = la; v.ld_wd = lw;
    v.cpu_rw = crw; v.cpu_addr = ca; v.cpu_wd = cw;
    v.e_haltN = eh; v.e_gnt = eg; v.e_rv = ev; v.e_rw = erw;
    v.e_addr = ea; v.e_wd = ew; v.chk_d = cd; v.e_d = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[20];
  logic [7:0] rd_exp [4];

  initial begin
    int acc;
    int kr;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    // ld_req, ld_rw, ld_addr, ld_wd, cpu_rw, cpu_addr, cpu_wd, haltN, gnt, rv, ram_rw, ram_addr, ram_wd, chk_d, data
    vecs[0]  = mk(0,1,8'h00,8'h00, 0,8'h10,8'h5A, 1,0,0, 0,8'h10,8'h5A, 0,8'h00);
    vecs[1]  = mk(0,1,8'h00,8'h00, 1,8'h10,8'h00, 1,0,0, 1,8'h10,8'h00, 0,8'h00);
    vecs[2]  = mk(0,1,8'h00,8'h00, 1,8'h10,8'h00, 1,0,0, 1,8'h10,8'h00, 1,8'h5A);
    vecs[3]  = mk(1,0,8'h00,8'h01, 1,8'h10,8'h00, 1,0,0, 1,8'h10,8'h00, 1,8'h5A);
    vecs[4]  = mk(1,0,8'h00,8'h01, 1,8'h10,8'h00, 0,0,0, 1,8'h10,8'h00, 1,8'h5A);
    vecs[5]  = mk(1,0,8'h00,8'h01, 1,8'h10,8'h00, 0,1,0, 0,8'h00,8'h01, 0,8'h00);
    vecs[6]  = mk(1,0,8'h01,8'h02, 1,8'h10,8'h00, 0,1,0, 0,8'h01,8'h02, 0,8'h00);
    vecs[7]  = mk(1,0,8'h02,8'h03, 1,8'h10,8'h00, 0,1,0, 0,8'h02,8'h03, 0,8'h00);
    vecs[8]  = mk(0,1,8'h02,8'h03, 1,8'h10,8'h00, 0,1,0, 1,8'h02,8'h00, 0,8'h00);
    vecs[9]  = mk(0,1,8'h00,8'h00, 1,8'h10,8'h00, 0,0,0, 1,8'h10,8'h00, 0,8'h00);
    vecs[10] = mk(0,1,8'h00,8'h00, 0,8'h20,8'hC3, 1,0,0, 0,8'h20,8'hC3, 1,8'h5A);
    vecs[11] = mk(1,1,8'h20,8'h00, 1,8'h00,8'h00, 1,0,0, 1,8'h00,8'h00, 0,8'h00);
    vecs[12] = mk(1,1,8'h20,8'h00, 1,8'h01,8'h00, 1,0,0, 1,8'h01,8'h00, 1,8'h01);
    vecs[13] = mk(1,1,8'h20,8'h00, 1,8'h02,8'h00, 1,0,0, 1,8'h02,8'h00, 1,8'h02);
    vecs[14] = mk(1,1,8'h20,8'h00, 1,8'h10,8'h00, 1,0,0, 1,8'h10,8'h00, 1,8'h03);
    vecs[15] = mk(1,1,8'h20,8'h00, 1,8'h10,8'h00, 0,0,0, 1,8'h10,8'h00, 1,8'h5A);
    vecs[16] = mk(1,1,8'h20,8'h00, 1,8'h10,8'h00, 0,1,0, 1,8'h20,8'h00, 0,8'h00);
    vecs[17] = mk(0,1,8'h20,8'h00, 1,8'h10,8'h00, 0,1,1, 1,8'h20,8'h00, 1,8'hC3);
    vecs[18] = mk(0,1,8'h00,8'h00, 1,8'h10,8'h00, 0,0,0, 1,8'h10,8'h00, 1,8'hC3);
    vecs[19] = mk(0,1,8'h00,8'h00, 1,8'h10,8'h00, 1,0,0, 1,8'h10,8'h00, 1,8'h5A);

    rd_exp[0] = 8'h01; rd_exp[1] = 8'h02; rd_exp[2] = 8'h03; rd_exp[3] = 8'h00;

    // Reset values
    #2 reset = 1'b1;
    #1;
    chk("rst haltN", 8'(cpu_haltN), 8'h01);
    chk("rst gnt", 8'(ld_gnt), 8'h00);
    chk("rst rvalid", 8'(ld_rvalid), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    next_cycle();

    // Pass-through, loader write burst, loader read, window delay
    for (int i = 0; i < 20; i++) begin
      ld_req = vecs[i].ld_req; ld_readWriteN = vecs[i].ld_rw;
      ld_address = vecs[i].ld_addr; ld_wdata = vecs[i].ld_wd;
      cpu_readWriteN = vecs[i].cpu_rw; cpu_address = vecs[i].cpu_addr;
      cpu_data_out = vecs[i].cpu_wd;
      @(negedge clk);
      chk($sformatf("v%0d haltN", i), 8'(cpu_haltN), 8'(vecs[i].e_haltN));
      chk($sformatf("v%0d gnt", i), 8'(ld_gnt), 8'(vecs[i].e_gnt));
      chk($sformatf("v%0d rvalid", i), 8'(ld_rvalid), 8'(vecs[i].e_rv));
      chk($sformatf("v%0d ram_rw", i), 8'(ram_readWriteN), 8'(vecs[i].e_rw));
      chk($sformatf("v%0d ram_addr", i), ram_address, vecs[i].e_addr);
      if (!vecs[i].e_rw) chk($sformatf("v%0d ram_wdata", i), ram_data_out, vecs[i].e_wd);
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d cpu_data_in", i), cpu_data_in, vecs[i].e_d);
        chk($sformatf("v%0d ld_rdata", i), ld_rdata, vecs[i].e_d);
      end
      next_cycle();
    end

    // Fairness with ld_req held high; the frozen processor presents a write to 0x30
    ld_req = 1'b0; cpu_readWriteN = 1'b1; cpu_address = 8'h30;
    repeat (6) next_cycle();
    acc = 0;
    kr = 0;
    for (int c = 0; c < 18; c++) begin
      ld_req = 1'b1; ld_readWriteN = 1'b1; ld_address = 8'(acc % 4);
      cpu_address = 8'h30; cpu_data_out = 8'h77;
      cpu_readWriteN = cpu_haltN ? 1'b1 : 1'b0;
      @(negedge clk);
      chk($sformatf("fair%0d haltN", c), 8'(cpu_haltN), 8'((c == 0) || (c >= 7 && c <= 11)));
      chk($sformatf("fair%0d gnt", c), 8'(ld_gnt), 8'((c >= 2 && c <= 5) || (c >= 13 && c <= 16)));
      chk($sformatf("fair%0d rvalid", c), 8'(ld_rvalid), 8'((c >= 3 && c <= 6) || (c >= 14 && c <= 17)));
      chk($sformatf("fair%0d ram_rw", c), 8'(ram_readWriteN), 8'h01);
      if (ld_gnt) acc++;
      if (ld_rvalid) begin
        chk($sformatf("fair%0d ld_rdata", c), ld_rdata, rd_exp[kr % 4]);
        kr++;
      end
      if (c == 7) begin
        chk("resume cpu_data_in", cpu_data_in, 8'h00);
        chk("frozen write mem30", mem[8'h30], 8'h00);
      end
      next_cycle();
    end
    ld_req = 1'b0;
    cpu_readWriteN = 1'b1;
    chk("fair accepts", 8'(acc), 8'd8);

    // Async reset in LOAD with a read in flight
    repeat (6) next_cycle();
    ld_req = 1'b1; ld_readWriteN = 1'b1; ld_address = 8'h20;
    repeat (3) next_cycle();
    chk("pre-rst gnt", 8'(ld_gnt), 8'h01);
    chk("pre-rst rvalid", 8'(ld_rvalid), 8'h01);
    reset = 1'b1;
    #1;
    chk("midrst haltN", 8'(cpu_haltN), 8'h01);
    chk("midrst gnt", 8'(ld_gnt), 8'h00);
    chk("midrst rvalid", 8'(ld_rvalid), 8'h00);
    @(negedge clk) reset = 1'b0;
    cpu_readWriteN = 1'b0; cpu_address = 8'h40; cpu_data_out = 8'h11;
    #1;
    chk("post-rst ram_rw", 8'(ram_readWriteN), 8'h00);
    chk("post-rst ram_addr", ram_address, 8'h40);
    chk("post-rst rvalid", 8'(ld_rvalid), 8'h00);
    next_cycle();
    chk("post-rst halt", 8'(cpu_haltN), 8'h00);
    chk("post-rst halt ram_rw", 8'(ram_readWriteN), 8'h01);
    next_cycle();
    chk("post-rst gnt", 8'(ld_gnt), 8'h01);
    chk("post-rst mem40", mem[8'h40], 8'h11);
    ld_req = 1'b0;
    cpu_readWriteN = 1'b1;
    repeat (2) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
